// File: rtl/stream_fifo_pkg.sv
// Shared constants and stage encodings for the serial-to-interpreter byte FIFO.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package stream_fifo_pkg;

  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;
  localparam logic TRUE_n  = 1'b0;
  localparam logic FALSE_n = 1'b1;

  localparam int DEFAULT_DEPTH_LOG2 = 8;
  // Bytes the receiver may still deliver after rts_n rises.
  localparam int RTS_SKID = 4;

  typedef enum logic [1:0] {
    STAGE_IDLE    = 2'd0,
    STAGE_FETCH   = 2'd1,
    STAGE_PRESENT = 2'd2
  } stage_e;

  // Fill level at which the fixed-threshold flow control stops the host.
  function automatic int skid_level(input int depth_log2);
    return (1 << depth_log2) - RTS_SKID;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Bundles the receiver side, interpreter side and status signals of the byte FIFO.
// Latency: n/a (wiring only).
// Backpressure: ready_n from the interpreter; rts_n toward the host.
interface stream_fifo_if import stream_fifo_pkg::*; #(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) ();

  logic [7:0]          rx_data;
  logic                rx_available;
  logic                ready_n;
  logic                overrun_clear;
  logic [7:0]          unicode;
  logic                unicode_available;
  logic                rts_n;
  logic                overrun;
  logic [DEPTH_LOG2:0] fill_level;

  modport master (
    output rx_data, rx_available, ready_n, overrun_clear,
    input  unicode, unicode_available, rts_n, overrun, fill_level
  );

  modport slave (
    input  rx_data, rx_available, ready_n, overrun_clear,
    output unicode, unicode_available, rts_n, overrun, fill_level
  );

endinterface

// File: rtl/stream_fifo_ram.sv
// Simple dual-port byte store: one write port, one registered read port.
// Latency: read data valid the cycle after rd_en; read-during-write returns old data.
// Backpressure: none; caller guarantees address validity.
module stream_fifo_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // Write and registered read share one process so a same-address read sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// Byte FIFO between serial receiver and stream interpreter, with rts_n flow control and sticky overrun.
// Latency: push in cycle t into an empty FIFO with ready_n low -> unicode_available in t+3; 1 byte / 3 cycles max.
// Backpressure: new read only from IDLE with ready_n low; rts_n rises near full (STREAM_FIFO_WATERMARK_EN selects hysteresis).
module stream_fifo import stream_fifo_pkg::*; #(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int HIGH_WATER = 192,
  parameter int LOW_WATER  = 64
) (
  input  logic         clk,
  input  logic         reset,
  stream_fifo_if.slave bus
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [CNT_W-1:0] SKID_CNT  = CNT_W'(skid_level(DEPTH_LOG2));
  localparam logic [CNT_W-1:0] HIGH_CNT  = CNT_W'(HIGH_WATER);
  localparam logic [CNT_W-1:0] LOW_CNT   = CNT_W'(LOW_WATER);

`ifdef STREAM_FIFO_WATERMARK_EN
  localparam bit HYSTERESIS = 1'b1;
`else
  localparam bit HYSTERESIS = 1'b0;
`endif

  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  stage_e                stage_q;
  stage_e                stage_nxt;
  logic                  issue;
  logic                  push_ok;
  logic                  drop;
  logic [7:0]            ram_q;
  logic [7:0]            unicode_q;
  logic                  avail_q;
  logic                  rts_n_q;
  logic                  rts_n_nxt;
  logic                  overrun_q;

  // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
  assign push_ok = bus.rx_available && ((count_q != DEPTH_CNT) || issue);
  assign drop    = bus.rx_available && !push_ok;

  stream_fifo_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.rx_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_q)
  );

  // Output stage sequencing; reads only start from IDLE so ready_n reflects the last byte.
  always_comb begin
    stage_nxt = stage_q;
    issue     = FALSE;
    case (stage_q)
      STAGE_IDLE: begin
        if ((count_q != '0) && (bus.ready_n == TRUE_n)) begin
          issue     = TRUE;
          stage_nxt = STAGE_FETCH;
        end
      end
      STAGE_FETCH:   stage_nxt = STAGE_PRESENT;
      STAGE_PRESENT: stage_nxt = STAGE_IDLE;
      default:       stage_nxt = STAGE_IDLE;
    endcase
  end

  // Occupancy: push and read issue in the same cycle cancel out.
  always_comb begin
    count_nxt = count_q;
    if (push_ok && !issue) begin
      count_nxt = count_q + 1'b1;
    end else if (!push_ok && issue) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Host flow control from next occupancy: fixed skid threshold or hysteresis band.
  always_comb begin
    rts_n_nxt = rts_n_q;
    if (HYSTERESIS) begin
      if (count_nxt >= HIGH_CNT) begin
        rts_n_nxt = FALSE_n;
      end else if (count_nxt <= LOW_CNT) begin
        rts_n_nxt = TRUE_n;
      end
    end else begin
      rts_n_nxt = (count_nxt >= SKID_CNT) ? FALSE_n : TRUE_n;
    end
  end

  // Stage register, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q  <= STAGE_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      stage_q  <= stage_nxt;
      count_q  <= count_nxt;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Registered outputs: byte capture on FETCH, one-cycle strobe, flow control, sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      unicode_q <= '0;
      avail_q   <= FALSE;
      rts_n_q   <= TRUE_n;
      overrun_q <= FALSE;
    end else begin
      avail_q <= (stage_q == STAGE_FETCH);
      if (stage_q == STAGE_FETCH) unicode_q <= ram_q;
      rts_n_q <= rts_n_nxt;
      if (drop) begin
        overrun_q <= TRUE;
      end else if (bus.overrun_clear) begin
        overrun_q <= FALSE;
      end
    end
  end

  assign bus.unicode           = unicode_q;
  assign bus.unicode_available = avail_q;
  assign bus.rts_n             = rts_n_q;
  assign bus.overrun           = overrun_q;
  assign bus.fill_level        = count_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: vector table, directed corner sequences, random traffic vs queue model.
// Latency: model expects the strobe 3 cycles after a push into an empty FIFO.
// Backpressure: exercises ready_n stalls, full-FIFO drops and rts_n thresholds (STREAM_FIFO_WATERMARK_EN aware).
module tb_stream_fifo;
  import stream_fifo_pkg::*;

  localparam int DL2   = 8;
  localparam int DEPTH = 256;
`ifdef STREAM_FIFO_WATERMARK_EN
  localparam int RTS_ON  = 192;
  localparam int RTS_OFF = 64;
`else
  localparam int RTS_ON  = 252;
  localparam int RTS_OFF = 251;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_fifo_if #(.DEPTH_LOG2(DL2)) bus();

  stream_fifo #(
    .DEPTH_LOG2 (DL2),
    .HIGH_WATER (192),
    .LOW_WATER  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: byte queue plus the byte currently travelling to the output.
  logic [7:0] mq[$];
  logic [7:0] inflight;
  int         busy_left;
  logic       m_av;
  logic [7:0] m_u;
  logic       m_ovr;
  logic       m_rts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present during that cycle.
  task automatic model_edge(input logic rav, input logic [7:0] rd, input logic rn,
                            input logic oc, input logic rs);
    logic start;
    logic dropped;
    if (rs) begin
      mq.delete();
      busy_left = 0;
      m_av  = 1'b0;
      m_u   = 8'h00;
      m_ovr = 1'b0;
      m_rts = 1'b0;
    end else begin
      start = (busy_left == 0) && (mq.size() != 0) && !rn;
      // A byte is shown two edges after its read starts, then the strobe drops.
      m_av = (busy_left == 2);
      if (busy_left == 2) m_u = inflight;
      if (busy_left != 0) busy_left--;
      if (start) begin
        inflight  = mq.pop_front();
        busy_left = 2;
      end
      dropped = 1'b0;
      if (rav) begin
        if (mq.size() < DEPTH) mq.push_back(rd);
        else dropped = 1'b1;
      end
      if (dropped) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
`ifdef STREAM_FIFO_WATERMARK_EN
      if (mq.size() >= RTS_ON) m_rts = 1'b1;
      else if (mq.size() <= RTS_OFF) m_rts = 1'b0;
`else
      m_rts = (mq.size() >= DEPTH - 4);
`endif
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output to the model.
  task automatic step(input logic rav, input logic [7:0] rd, input logic rn,
                      input logic oc, input logic rs);
    bus.rx_available  = rav;
    bus.rx_data       = rd;
    bus.ready_n       = rn;
    bus.overrun_clear = oc;
    reset             = rs;
    @(posedge clk);
    model_edge(rav, rd, rn, oc, rs);
    #1;
    cyc++;
    chk("model_unicode_available", bus.unicode_available, m_av);
    chk("model_unicode", bus.unicode, m_u);
    chk("model_fill_level", bus.fill_level, mq.size());
    chk("model_rts_n", bus.rts_n, m_rts);
    chk("model_overrun", bus.overrun, m_ovr);
  endtask

  typedef struct {
    logic       rav;
    logic [7:0] rd;
    logic       rn;
    logic [7:0] u;
    logic       av;
    int         fill;
  } vec_t;

  vec_t tbl[17];
  logic [7:0] exp_bytes[$];
  logic [7:0] got;
  int waited;
  int strobes;
  int received;
  logic seen;

  initial begin
    busy_left = 0;
    m_av = 1'b0; m_u = 8'h00; m_ovr = 1'b0; m_rts = 1'b0;
    bus.rx_available = 1'b0; bus.rx_data = 8'h00; bus.ready_n = 1'b1;
    bus.overrun_clear = 1'b0; reset = 1'b1;

    // Reset values.
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    chk("reset_unicode_available", bus.unicode_available, 1'b0);
    chk("reset_unicode", bus.unicode, 8'h00);
    chk("reset_fill_level", bus.fill_level, 9'd0);
    chk("reset_rts_n", bus.rts_n, 1'b0);
    chk("reset_overrun", bus.overrun, 1'b0);

    // Single byte, then three bytes held by ready_n and released one per 3 cycles.
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 0};
    tbl[5]  = '{1'b1, 8'h31, 1'b1, 8'h41, 1'b0, 1};
    tbl[6]  = '{1'b1, 8'h32, 1'b1, 8'h41, 1'b0, 2};
    tbl[7]  = '{1'b1, 8'h33, 1'b1, 8'h41, 1'b0, 3};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 2};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 2};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b0, 2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b0, 1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b1, 1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b0, 1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b0, 0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rav, tbl[i].rd, tbl[i].rn, 1'b0, 1'b0);
      chk($sformatf("vec%0d_unicode_available", i), bus.unicode_available, tbl[i].av);
      chk($sformatf("vec%0d_unicode", i), bus.unicode, tbl[i].u);
      chk($sformatf("vec%0d_fill_level", i), bus.fill_level, tbl[i].fill);
    end

    // Interpreter busy for 20 cycles after every byte.
    exp_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      exp_bytes.push_back(8'hA0 + 8'(i));
      step(1, 8'hA0 + 8'(i), 1, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      seen = 1'b0;
      while (!seen && waited < 12) begin
        step(0, 8'h00, 0, 0, 0);
        waited++;
        if (bus.unicode_available) seen = 1'b1;
      end
      chk("busy_strobe_seen", seen, 1'b1);
      chk("busy_gap_at_least_2", (waited >= 2), 1'b1);
      chk("busy_byte", bus.unicode, exp_bytes[k]);
      strobes = 0;
      for (int j = 0; j < 20; j++) begin
        step(0, 8'h00, 1, 0, 0);
        if (bus.unicode_available) strobes++;
      end
      chk("busy_no_strobe_while_held", strobes, 0);
    end
    chk("busy_drained", bus.fill_level, 9'd0);

    // Fill to capacity, drop one byte, clear overrun, drain across the pointer wrap.
    exp_bytes.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_bytes.push_back(8'((i * 37 + 5) & 255));
      step(1, 8'((i * 37 + 5) & 255), 1, 0, 0);
      if (i + 1 == RTS_ON - 1) chk("rts_below_high", bus.rts_n, 1'b0);
      if (i + 1 == RTS_ON)     chk("rts_at_high", bus.rts_n, 1'b1);
    end
    chk("full_fill_level", bus.fill_level, 9'd256);
    chk("full_no_overrun_yet", bus.overrun, 1'b0);
    step(1, 8'hEE, 1, 0, 0);
    chk("drop_overrun_set", bus.overrun, 1'b1);
    chk("drop_fill_unchanged", bus.fill_level, 9'd256);
    step(0, 8'h00, 1, 1, 0);
    chk("overrun_cleared", bus.overrun, 1'b0);
    received = 0;
    waited = 0;
    while (received < DEPTH && waited < 900) begin
      step(0, 8'h00, 0, 0, 0);
      waited++;
      if (bus.unicode_available) begin
        chk($sformatf("drain_byte%0d", received), bus.unicode, exp_bytes[received]);
        received++;
      end
      if (bus.fill_level == RTS_OFF + 1) chk("rts_above_low", bus.rts_n, 1'b1);
      if (bus.fill_level == RTS_OFF)     chk("rts_at_low", bus.rts_n, 1'b0);
    end
    chk("drain_count", received, DEPTH);

    // Reset while a byte is in FETCH with 10 queued.
    for (int i = 0; i < 10; i++) step(1, 8'h60 + 8'(i), 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("pre_reset_fill", bus.fill_level, 9'd9);
    step(0, 8'h00, 0, 0, 1);
    chk("midreset_unicode_available", bus.unicode_available, 1'b0);
    chk("midreset_fill_level", bus.fill_level, 9'd0);
    chk("midreset_rts_n", bus.rts_n, 1'b0);
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("post_reset_no_early_strobe", bus.unicode_available, 1'b0);
    step(0, 8'h00, 0, 0, 0);
    chk("post_reset_strobe", bus.unicode_available, 1'b1);
    chk("post_reset_byte", bus.unicode, 8'h55);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 3, $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
